dac_ltc2624_receiver: RTL
=========================

# dac_ltc2624_receiver

Synthesizable responder for the LTC2624 quad 12-bit DAC serial protocol. It decodes 32-bit SPI command frames driven by the DAC controller in `Top`, maintains the four channel input/DAC registers and power-down state, and echoes the previous frame on `DAC_OUT` as the real part does. It sits on the same `SPI_SCK`/`DAC_CS`/`DAC_CLR`/`SPI_MOSI`/`DAC_OUT` nets as the behavioural DAC model. It serves as an on-chip loopback target and as a self-checking bench peer.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `SPI_SCK`, `DAC_CS`, `DAC_CLR`, `SPI_MOSI` (min 2).
- `ECHO`, 1: 1 drives the previous frame on `DAC_OUT`; 0 holds `DAC_OUT` low.

Ports:
- `CLK50MHZ` in 1: system clock, the only clock in the block.
- `RST` in 1: synchronous, active-high reset.
- `SPI_SCK` in 1: serial clock from the controller, asynchronous to `CLK50MHZ`.
- `DAC_CS` in 1: active-low frame select.
- `DAC_CLR` in 1: active-low clear.
- `SPI_MOSI` in 1: serial data, MSB first.
- `DAC_OUT` out 1: SDO echo.
- `FRAME_VALID` out 1: one-cycle pulse when a well-formed frame completes.
- `FRAME_ERR` out 1: one-cycle pulse when a frame completes with a bit count other than 32 (count 0 excluded).
- `CMD` out 4: command of the last valid frame.
- `ADDR` out 4: address of the last valid frame.
- `DATA` out 12: data of the last valid frame.
- `VOUT_A`, `VOUT_B`, `VOUT_C`, `VOUT_D` out 12 each: DAC registers.
- `PD` out 4: per-channel power-down flags, bit 0 = A.

## Operation
- **Input synchronization and edge detection.** All four inputs pass through `SYNC_STAGES` flops. Edge detection compares the last synchronized stage with one further registered copy, giving `sck_rise`, `sck_fall`, `cs_fall` and `cs_rise` single-cycle strobes.
- **FSM states.**
  - IDLE: on `cs_fall`, go to SHIFT. Clear the bit counter and load the echo register from the last complete frame.
  - SHIFT: on each `sck_rise`, shift synchronized MOSI into a 32-bit shift register (LSB in). The 6-bit counter increments and saturates at 63. On `cs_rise`, go to DONE.
  - DONE: one cycle. Count 32 gives `FRAME_VALID`, latches `CMD`/`ADDR`/`DATA` and executes the command. Count 1–31 or 33–63 gives `FRAME_ERR`, with no state change. Count 0 gives no pulse. Return to IDLE.
- **Frame layout**, bits 31..0: 8 don't-care, CMD[3:0], ADDR[3:0], DATA[11:0], 4 don't-care. The shift register contents of every frame with count ≥ 32 become the next echo word, using the last 32 bits.
- **Address decode.** 0–3 select A–D; 15 selects all four; any other address is a no-op but still gives `FRAME_VALID`.
- **Commands.**
  - 0000: write input register.
  - 0001: update DAC from input register.
  - 0011: write input and update DAC. This also clears PD.
  - 0100: set PD.
  - 1111 and all others: no-op.
  - Commands 0001 and 0011 also clear PD for the selected channel(s).
- **DAC_CLR.** While synchronized `DAC_CLR` is 0, all input and DAC registers are held at 0. Frames are still decoded and pulses still produced, but register writes are suppressed. PD is unaffected.
- **Echo.** On `cs_fall`, `DAC_OUT` drives echo bit 31. On each `sck_fall` in SHIFT, the echo register shifts left and `DAC_OUT` drives the new MSB. In IDLE, `DAC_OUT` holds its last value.
- **Reset.** A reset mid-frame discards the frame. If `DAC_CS` is low when reset releases, the block ignores it until a `cs_rise`/`cs_fall` pair occurs.

## Timing
- **Reset values:**
  - `DAC_OUT` 0; `FRAME_VALID` 0; `FRAME_ERR` 0.
  - `CMD`, `ADDR`, `DATA` 0.
  - `VOUT_A..D` 0; input registers 0; echo word 0.
  - `PD` 4'b0000; FSM IDLE.
- **Latency.** A pin edge becomes a strobe after `SYNC_STAGES`+1 cycles. `FRAME_VALID`/`FRAME_ERR` assert in the cycle after `cs_rise`. `CMD`/`ADDR`/`DATA`/`VOUT_*`/`PD` update in the same cycle as the pulse.
- **SCK constraints.** `SPI_SCK` high and low phases must each be ≥ `SYNC_STAGES`+2 clock cycles, which is 4 at the default. `DAC_OUT` changes `SYNC_STAGES`+1 cycles after the pin-level SCK fall, so it is stable before the controller samples on the next rising edge.
- **Simultaneous events.**
  - `sck_rise` and `cs_rise` in the same cycle: the bit is shifted first, then the FSM enters DONE.
  - `cs_fall` during DONE: taken in IDLE next cycle, so no edge is lost because DONE is one cycle.
  - `cs_rise` with the counter saturated at 63: reports `FRAME_ERR`.

## Test plan
- **Write-and-update.** Frame 0x0030ABC0 (cmd 3, addr 0, data 0xABC) → `FRAME_VALID` once; `CMD`=3, `ADDR`=0, `DATA`=0xABC; `VOUT_A`=0xABC; others 0.
- **Write then update.** Frame 0x000F1230 (write, addr 15) → `VOUT_*` unchanged. Then 0x001F0000 (update, all) → `VOUT_A..D`=0x123.
- **Bad frame lengths.** 31-bit frame → `FRAME_ERR` once, no register change. 33-bit frame → `FRAME_ERR`. CS pulse with no SCK → no pulse.
- **Echo.** Send 0x0030ABC0, then 0x00F00000 while capturing `DAC_OUT` on SCK rises → captured word equals 0x0030ABC0.
- **Clear and power-down.** `DAC_CLR` low for 10 cycles after channels are loaded → all `VOUT_*`=0. Frame 0x00420000 → `PD`=4'b0100. Frame 0x0032FFF0 → `VOUT_C`=0xFFF, `PD`=0.
- **Reset mid-frame.** Assert `RST` after 16 bits, keeping CS low → no pulse at CS rise. The next full frame decodes correctly. Every output is 0 during reset.

Source files
------------

// File: rtl/dac_ltc2624_receiver.sv
// LTC2624 quad 12-bit DAC serial responder: decodes 32-bit command frames,
// holds the channel input/DAC registers and power-down flags, echoes the previous frame.
module dac_ltc2624_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ECHO        = 1
) (
  input  logic        CLK50MHZ,
  input  logic        RST,
  input  logic        SPI_SCK,
  input  logic        DAC_CS,
  input  logic        DAC_CLR,
  input  logic        SPI_MOSI,
  output logic        DAC_OUT,
  output logic        FRAME_VALID,
  output logic        FRAME_ERR,
  output logic [3:0]  CMD,
  output logic [3:0]  ADDR,
  output logic [11:0] DATA,
  output logic [11:0] VOUT_A,
  output logic [11:0] VOUT_B,
  output logic [11:0] VOUT_C,
  output logic [11:0] VOUT_D,
  output logic [3:0]  PD
);

  localparam int unsigned FRAME_W = 32;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned NCH     = 4;

  localparam logic [3:0] CMD_WRITE  = 4'h0;
  localparam logic [3:0] CMD_UPDATE = 4'h1;
  localparam logic [3:0] CMD_WRUPD  = 4'h3;
  localparam logic [3:0] CMD_PWRDN  = 4'h4;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, clr_sync_q, mosi_sync_q;
  logic                   sck_dly_q, cs_dly_q;
  logic                   sck_s, cs_s, clr_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d, echo_q, echo_d, last_q, last_d;
  logic                 dout_q, dout_d, valid_q, valid_d, err_q, err_d, pend_q, pend_d;
  logic [3:0]           cmd_q, cmd_d, addr_q, addr_d, pd_q, pd_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [DATA_W-1:0]    in_q [NCH];
  logic [DATA_W-1:0]    in_d [NCH];
  logic [DATA_W-1:0]    dac_q [NCH];
  logic [DATA_W-1:0]    dac_d [NCH];
  logic                 finish;
  logic [3:0]           mask;

  // CS resets low so a frame already in progress at reset release is ignored
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      clr_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], DAC_CS};
      clr_sync_q  <= {clr_sync_q[SYNC_STAGES-2:0], DAC_CLR};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      sck_dly_q   <= sck_s;
      cs_dly_q    <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign clr_s    = clr_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_dly_q;
  assign sck_fall = ~sck_s & sck_dly_q;
  assign cs_fall  = ~cs_s & cs_dly_q;
  assign cs_rise  = cs_s & ~cs_dly_q;

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      echo_q  <= '0;
      last_q  <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      pd_q    <= '0;
      in_q    <= '{default: '0};
      dac_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      echo_q  <= echo_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pd_q    <= pd_d;
      in_q    <= in_d;
      dac_q   <= dac_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    echo_d  = echo_q;
    last_d  = last_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    pend_d  = pend_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pd_d    = pd_q;
    in_d    = in_q;
    dac_d   = dac_q;
    finish  = 1'b0;
    mask    = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (cs_fall || pend_q) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          pend_d  = 1'b0;
          echo_d  = last_q;
          dout_d  = (ECHO != 0) ? last_q[FRAME_W-1] : 1'b0;
        end
      end
      S_SHIFT: begin
        // a bit arriving with cs_rise is shifted before the frame is judged
        if (sck_rise) begin
          shift_d = {shift_q[FRAME_W-2:0], mosi_s};
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end
        if (sck_fall) begin
          echo_d = {echo_q[FRAME_W-2:0], echo_q[FRAME_W-1]};
          dout_d = (ECHO != 0) ? echo_q[FRAME_W-2] : 1'b0;
        end
        if (cs_rise) begin
          state_d = S_DONE;
          finish  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (cs_fall) pend_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // pulses and command effects land together in the DONE cycle
    if (finish) begin
      if (cnt_d == CNT_W'(32)) begin
        valid_d = 1'b1;
        cmd_d   = shift_d[23:20];
        addr_d  = shift_d[19:16];
        data_d  = shift_d[15:4];
        if (shift_d[19:16] == 4'hF)      mask = 4'b1111;
        else if (shift_d[19:16] < 4'd4)  mask = 4'b0001 << shift_d[17:16];
        for (int i = 0; i < NCH; i++) begin
          if (mask[i]) begin
            case (shift_d[23:20])
              CMD_WRITE:  in_d[i] = shift_d[15:4];
              CMD_UPDATE: begin dac_d[i] = in_q[i]; pd_d[i] = 1'b0; end
              CMD_WRUPD:  begin
                in_d[i]  = shift_d[15:4];
                dac_d[i] = shift_d[15:4];
                pd_d[i]  = 1'b0;
              end
              CMD_PWRDN:  pd_d[i] = 1'b1;
              default:    ;
            endcase
          end
        end
      end else if (cnt_d != '0) begin
        err_d = 1'b1;
      end
      if (cnt_d >= CNT_W'(32)) last_d = shift_d;
    end

    if (!clr_s) begin
      in_d  = '{default: '0};
      dac_d = '{default: '0};
    end
  end

  assign DAC_OUT     = dout_q;
  assign FRAME_VALID = valid_q;
  assign FRAME_ERR   = err_q;
  assign CMD         = cmd_q;
  assign ADDR        = addr_q;
  assign DATA        = data_q;
  assign VOUT_A      = dac_q[0];
  assign VOUT_B      = dac_q[1];
  assign VOUT_C      = dac_q[2];
  assign VOUT_D      = dac_q[3];
  assign PD          = pd_q;

endmodule
